// File: rtl/vga_fetch_pkg.sv
// Shared definitions for the VGA framebuffer read agent: SDRAM interface
// widths, controller read latency and the fetch FSM state encoding.
package vga_fetch_pkg;

    localparam int SDRAM_ADDR_W      = 20;
    localparam int SDRAM_DATA_W      = 16;
    localparam int CTRL_READ_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/vga_line_fetch_fifo.sv
// First-word-fall-through synchronous FIFO. The head word is visible on dout
// in the same cycle empty falls; dout reads as zero while empty so no stale
// word is ever presented downstream. flush empties the FIFO in one cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & (count_q != FULL_COUNT);
    assign do_pop  = pop & ~empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write port.
    // NOTE: the data array has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vga_line_fetch.sv
// Framebuffer read agent: walks the frame region one word at a time, issues
// reads to the SDRAM controller under credit control, buffers the returned
// words and streams them to the pixel pipeline.
module vga_line_fetch
    import vga_fetch_pkg::*;
#(
    parameter int                      FIFO_DEPTH  = 64,
    parameter logic [SDRAM_ADDR_W-1:0] BASE_ADDR   = 20'h00000,
    parameter int                      FRAME_WORDS = 307200,
    parameter int                      DRAIN_CYC   = CTRL_READ_LATENCY + 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          frame_sync,
    output logic                          RdReq,
    input  logic                          RdGnt,
    output logic [SDRAM_ADDR_W-1:0]       RdAddr,
    input  logic [SDRAM_DATA_W-1:0]       RdData,
    input  logic                          RdDataValid,
    output logic [SDRAM_DATA_W-1:0]       pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam logic [LW-1:0]           DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [SDRAM_ADDR_W-1:0] LAST_WORD = SDRAM_ADDR_W'(FRAME_WORDS - 1);

    fetch_state_t            state_q, state_d;
    logic [SDRAM_ADDR_W-1:0] addr_q;
    logic [SDRAM_ADDR_W-1:0] word_cnt_q;
    logic [LW-1:0]           inflight_q;
    logic [LW-1:0]           credits;
    logic [TW-1:0]           drain_timer_q;
    logic                    drain_by_timer_q;
    logic                    underflow_q;
    logic                    rd_req;
    logic                    gnt;
    logic                    ret;
    logic                    push;
    logic                    flush;
    logic                    fifo_empty;

    // Credits count free FIFO slots not already promised to reads in flight.
    assign credits = DEPTH_L - fifo_level - inflight_q;
    assign rd_req  = (state_q == FETCH) & enable & (credits != '0);
    assign gnt     = RdGnt & rd_req;
    assign ret     = RdDataValid & (inflight_q != '0);
    assign push    = ret & (state_q == FETCH) & ~frame_sync;

    assign RdReq     = rd_req;
    assign RdAddr    = addr_q;
    assign pix_valid = ~fifo_empty;
    assign underflow = underflow_q;

    // Next-state logic; the FIFO flush fires on the cycle DRAIN is left.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_sync)  state_d = DRAIN;
                else if (enable) state_d = FETCH;
            end
            FETCH: begin
                if (frame_sync)                        state_d = DRAIN;
                else if (!enable && inflight_q == '0)  state_d = IDLE;
            end
            DRAIN: begin
                if (!frame_sync && (drain_by_timer_q ? (drain_timer_q == '0)
                                                     : (inflight_q == '0))) begin
                    flush   = 1'b1;
                    state_d = enable ? FETCH : IDLE;
                end
            end
            default: state_d = DRAIN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= DRAIN;
        else       state_q <= state_d;
    end

    // Reads granted but not yet returned (or discarded while draining).
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
        end else begin
            case ({gnt, ret})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // After reset the drain is timed; a frame_sync switches it to waiting on inflight.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_timer_q    <= TW'(DRAIN_CYC);
            drain_by_timer_q <= 1'b1;
        end else if (frame_sync) begin
            drain_by_timer_q <= 1'b0;
        end else if (state_q == DRAIN && drain_by_timer_q && drain_timer_q != '0) begin
            drain_timer_q <= drain_timer_q - 1'b1;
        end
    end

    // Address generator: advances on each grant and wraps at the end of the frame.
    always_ff @(posedge clk) begin
        if (reset || frame_sync) begin
            addr_q     <= BASE_ADDR;
            word_cnt_q <= '0;
        end else if (gnt) begin
            if (word_cnt_q == LAST_WORD) begin
                addr_q     <= BASE_ADDR;
                word_cnt_q <= '0;
            end else begin
                addr_q     <= addr_q + 1'b1;
                word_cnt_q <= word_cnt_q + 1'b1;
            end
        end
    end

    // Sticky underflow: consumer asked for a pixel while fetching with nothing buffered.
    always_ff @(posedge clk) begin
        if (reset || frame_sync) begin
            underflow_q <= 1'b0;
        end else if (state_q == FETCH && pix_ready && fifo_empty) begin
            underflow_q <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (SDRAM_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (RdData),
        .pop   (pix_ready),
        .flush (flush),
        .dout  (pix_data),
        .empty (fifo_empty),
        .count (fifo_level)
    );

endmodule

// File: tb/tb_vga_line_fetch.sv
// Self-checking bench for vga_line_fetch: a randomised SDRAM controller model
// (latency 4) drives the read port, and a queue-based reference model of the
// pixel stream, address sequence and credit rule checks the DUT every cycle.
module tb_vga_line_fetch;

    localparam int          DEPTH = 64;
    localparam logic [19:0] BASE  = 20'h00A00;
    localparam int          FW    = 16;
    localparam int          DCYC  = 6;
    localparam int          LAT   = 4;

    logic        clk = 1'b0;
    logic        reset, enable, frame_sync;
    logic        RdReq, RdGnt, RdDataValid;
    logic [19:0] RdAddr;
    logic [15:0] RdData, pix_data;
    logic        pix_valid, pix_ready, underflow;
    logic [6:0]  fifo_level;

    always #5 clk = ~clk;

    vga_line_fetch #(
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (BASE),
        .FRAME_WORDS (FW),
        .DRAIN_CYC   (DCYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_sync  (frame_sync),
        .RdReq       (RdReq),
        .RdGnt       (RdGnt),
        .RdAddr      (RdAddr),
        .RdData      (RdData),
        .RdDataValid (RdDataValid),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .underflow   (underflow),
        .fifo_level  (fifo_level)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
        int          gen;
        int          epoch;
    } rd_t;

    typedef enum int {M_IDLE, M_FETCH, M_DRAIN} mode_t;

    rd_t         pend[$];        // reads issued to the controller model
    logic [15:0] exp_fifo[$];    // words the consumer should see, in order
    logic [15:0] mem_tbl [256];
    mode_t       mode;
    bit          by_timer, uf;
    int          rst_age, word_idx, cur_gen, cur_epoch, cyc, n_gnt;
    int          tests, fails;
    int          first_gnt, first_valid;
    bit          rst_i, en_i, fs_i, ready_i, rogue_i;
    int          gnt_pct;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int inflight_now();
        int n = 0;
        foreach (pend[i]) if (pend[i].epoch == cur_epoch) n++;
        return n;
    endfunction

    // One clock cycle: drive inputs, check outputs, answer requests, advance the model.
    task automatic tick();
        rd_t         r;
        bit          ret, g, pop, acc, exp_req, nxt_uf;
        int          infl;
        logic [15:0] rdat;
        logic [19:0] ea;
        ret         = (pend.size() != 0) && (pend[0].due == cyc);
        reset       = rst_i;
        enable      = en_i;
        frame_sync  = fs_i;
        pix_ready   = ready_i;
        RdDataValid = ret;
        RdData      = ret ? pend[0].data : 16'($urandom);
        RdGnt       = 1'b0;
        #1;
        infl    = inflight_now();
        exp_req = (mode == M_FETCH) && en_i && ((DEPTH - exp_fifo.size() - infl) != 0);
        if (!rst_i) begin
            check("rdreq", RdReq, exp_req);
            check("fifo_level", fifo_level, exp_fifo.size());
            check("pix_valid", pix_valid, exp_fifo.size() != 0);
            check("underflow", underflow, uf);
            check("credit_bound", (32'(fifo_level) + infl) <= DEPTH, 1);
            if (exp_fifo.size() != 0) check("pix_data", pix_data, exp_fifo[0]);
            if (pix_valid && first_valid < 0) first_valid = cyc;
        end
        g     = !rst_i && RdReq && ($urandom_range(99) < gnt_pct);
        RdGnt = g | (rogue_i & !RdReq);
        ea    = BASE + 20'(word_idx);
        if (g) begin
            check("rdaddr", RdAddr, ea);
            if (first_gnt < 0) first_gnt = cyc;
            n_gnt++;
        end
        pop  = (exp_fifo.size() != 0) && ready_i;
        acc  = 1'b0;
        rdat = '0;
        if (ret) begin
            r    = pend.pop_front();
            rdat = r.data;
            acc  = (r.epoch == cur_epoch) && (r.gen == cur_gen) && !fs_i && (mode == M_FETCH);
        end
        if (g) pend.push_back('{due: cyc + LAT, data: mem_tbl[ea[7:0]], gen: cur_gen, epoch: cur_epoch});
        if (rst_i) begin
            exp_fifo.delete();
            mode     = M_DRAIN;
            by_timer = 1'b1;
            rst_age  = 0;
            word_idx = 0;
            uf       = 1'b0;
            cur_epoch++;
            cur_gen++;
        end else begin
            nxt_uf = uf | ((mode == M_FETCH) && ready_i && exp_fifo.size() == 0);
            if (fs_i) nxt_uf = 1'b0;
            if (pop) void'(exp_fifo.pop_front());
            if (acc) exp_fifo.push_back(rdat);
            if (g) word_idx = (word_idx + 1) % FW;
            if (fs_i) begin
                word_idx = 0;
                cur_gen++;
            end
            case (mode)
                M_FETCH: begin
                    if (fs_i) begin mode = M_DRAIN; by_timer = 1'b0; end
                    else if (!en_i && infl == 0) mode = M_IDLE;
                end
                M_IDLE: begin
                    if (fs_i) begin mode = M_DRAIN; by_timer = 1'b0; end
                    else if (en_i) mode = M_FETCH;
                end
                default: begin
                    if (fs_i) by_timer = 1'b0;
                    else if (by_timer ? (rst_age == DCYC) : (infl == 0)) begin
                        exp_fifo.delete();
                        mode = en_i ? M_FETCH : M_IDLE;
                    end
                end
            endcase
            uf = nxt_uf;
            rst_age++;
        end
        @(posedge clk);
        #1;
        rogue_i = 1'b0;
        fs_i    = 1'b0;
        cyc++;
    endtask

    task automatic check_reset_values();
        check("rst_rdreq", RdReq, 0);
        check("rst_rdaddr", RdAddr, BASE);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_underflow", underflow, 0);
        check("rst_fifo_level", fifo_level, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_gnt;
        tests = 0; fails = 0; cyc = 0; n_gnt = 0;
        cur_gen = 0; cur_epoch = 0; word_idx = 0; uf = 0;
        mode = M_DRAIN; by_timer = 1; rst_age = 0;
        first_gnt = -1; first_valid = -1;
        foreach (mem_tbl[i]) mem_tbl[i] = 16'($urandom);
        reset = 1; enable = 0; frame_sync = 0; pix_ready = 0;
        RdGnt = 0; RdData = 0; RdDataValid = 0;
        rst_i = 1; en_i = 0; fs_i = 0; ready_i = 0; rogue_i = 0; gnt_pct = 100;
        @(posedge clk); #1;

        // Reset, then fill the FIFO with a stalled consumer.
        repeat (3) tick();
        rst_i = 0;
        check_reset_values();
        en_i = 1; ready_i = 0; gnt_pct = 100;
        for (int i = 0; i < 300 && fifo_level != 7'(DEPTH); i++) tick();
        repeat (5) tick();
        check("first_pix_latency", first_valid - first_gnt, 5);
        check("fill_level", fifo_level, DEPTH);
        check("fill_rdreq", RdReq, 0);

        // Free-running consumer across several frame wraps.
        ready_i = 1;
        repeat (80) tick();
        check("freerun_underflow", underflow, 0);

        // Randomised enable, consumer and grant pattern.
        gnt_pct = 70;
        for (int i = 0; i < 300; i++) begin
            en_i    = ($urandom_range(9) != 0);
            ready_i = $urandom_range(1);
            tick();
        end

        // frame_sync with exactly three reads in flight.
        en_i = 1; gnt_pct = 0; ready_i = 1;
        repeat (70) tick();
        ready_i = 0; gnt_pct = 100;
        base_gnt = n_gnt;
        repeat (3) tick();
        check("three_in_flight", n_gnt - base_gnt, 3);
        gnt_pct = 0; fs_i = 1;
        tick();
        repeat (6) tick();
        check("drain_flushed", fifo_level, 0);
        gnt_pct = 100;
        repeat (10) tick();
        ready_i = 1;
        repeat (20) tick();

        // Controller stall with a hungry consumer.
        gnt_pct = 0; ready_i = 1;
        repeat (100) tick();
        check("stall_underflow", underflow, 1);
        fs_i = 1;
        tick();
        tick();
        check("underflow_cleared", underflow, 0);

        // enable dropped with two reads in flight, plus a stray grant.
        ready_i = 0;
        repeat (8) tick();
        gnt_pct = 100;
        repeat (2) tick();
        en_i = 0; gnt_pct = 0;
        repeat (4) tick();
        rogue_i = 1;
        tick();
        repeat (5) tick();
        check("idle_level", fifo_level, 2);
        check("idle_rdreq", RdReq, 0);
        en_i = 1; gnt_pct = 100; ready_i = 1;
        repeat (20) tick();

        // Reset in the middle of a burst with returns still pending.
        ready_i = 0;
        repeat (6) tick();
        rst_i = 1;
        tick();
        rst_i = 0;
        check_reset_values();
        repeat (6) tick();
        check("post_reset_level", fifo_level, 0);
        ready_i = 1;
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
